act_lut_scheduler: RTL and testbench
====================================

# act_lut_scheduler

Time-multiplexes one combinational activation LUT between `N_REQ` neuron requesters in a layer. Arbitrates requests round-robin and drives the LUT `address`. Captures the LUT's `base`/`next__data` pair and optionally linearly interpolates between them using the input's low-order bits. Returns the activated value to the granted neuron with a one-cycle acknowledge. Sits between a layer's neuron accumulators and its shared `my_lut` instance.

## Interface
- `N_REQ`, 4: number of requesters (2..16).
- `IN_WIDTH`, 8: signed fixed-point pre-activation width.
- `ADDR_WIDTH`, 4: LUT address width; the upper `ADDR_WIDTH` bits of the input.
- `DATA_WIDTH`, 8: signed LUT entry and result width.
- `FRAC_WIDTH`, `IN_WIDTH-ADDR_WIDTH`: interpolation fraction width; the low input bits.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  `N_REQ`  per-requester request level.
- `req__data`  in  `N_REQ*IN_WIDTH`  packed inputs; requester i occupies bits `[i*IN_WIDTH +: IN_WIDTH]`.
- `ack`  out  `N_REQ`  one-hot, one-cycle completion pulse.
- `res__data`  out  `DATA_WIDTH` signed  result; valid while `res__valid`.
- `res__valid`  out  1  coincident with the `ack` pulse.
- `res__id`  out  `$clog2(N_REQ)`  index of the requester being served.
- `busy`  out  1  high in every state except IDLE.
- `address`  out  `ADDR_WIDTH`  to the LUT.
- `base`  in  `DATA_WIDTH` signed  `lut[address]` from the LUT.
- `next__data`  in  `DATA_WIDTH` signed  next entry from the LUT; the LUT owns clamp/wrap at the table ends.

## Operation
- FSM states: IDLE, ADDR, CALC, DONE.
- IDLE:
  - If any `req` is set, grant the first set bit at or after pointer `ptr`, searching upward modulo `N_REQ`.
  - Latch that requester's input into `in_q`, latch the grant index into `gnt_q`, go to ADDR.
  - If no `req` is set, stay in IDLE.
- ADDR:
  - `address` = `in_q[IN_WIDTH-1 -: ADDR_WIDTH]`.
  - Register `base`→`b_q`, `next__data`→`n_q`, `in_q[FRAC_WIDTH-1:0]`→`f_q`.
  - Go to CALC.
- CALC:
  - `res_q = b_q + ((n_q - b_q) * f_q) >>> FRAC_WIDTH`.
  - Compute the difference at `DATA_WIDTH+1` bits signed; `f_q` is zero-extended unsigned; the shift is arithmetic (floor).
  - The result always lies between `b_q` and `n_q` inclusive, so truncation to `DATA_WIDTH` is lossless.
  - Go to DONE.
- DONE:
  - `ack[gnt_q]`=1, `res__valid`=1, `res__id`=`gnt_q`, `res__data`=`res_q`.
  - `ptr` ← (`gnt_q`+1) mod `N_REQ`.
  - Go to IDLE.
- Requester contract: hold `req` and its data stable until `ack`, then deassert in the cycle after `ack`. `req` is not sampled in DONE, so a requester still high during its `ack` cycle is not re-granted. A requester may assert again after that and is then served again.
- `address` holds `in_q`'s upper bits in all states; it is 0 after reset.
- Reset in any state: FSM→IDLE, `ptr`=0, `ack`=0, `res__valid`=0, `res__data`=0, `res__id`=0, `busy`=0, `address`=0. An in-flight request is dropped without `ack`, and the requester must keep `req` asserted to be re-served.

## Timing
- Grant at IDLE edge t; ADDR at t+1; CALC at t+2; `ack`/`res__valid` visible during cycle t+3.
- Requester-visible latency: 4 cycles from first sampled `req` to `ack`.
- Throughput: one result per 4 cycles; the next grant is sampled in the IDLE cycle after DONE.
- LUT is combinational; `base`/`next__data` are sampled at the end of ADDR.
- All outputs are registered except `address`, which is driven from `in_q` (a register).

## Configuration
- `ACT_LUT_SCHED_INTERP_EN` defined: four-state FSM with interpolation, as above.
- Not defined:
  - CALC state and the multiplier are removed; ADDR goes straight to DONE with `res_q = base`; `next__data` is unused.
  - Latency is 3 cycles and throughput one result per 3 cycles.

## Structure
- Package `act_lut_sched_pkg`: state enum (IDLE, ADDR, CALC, DONE), default width constants, and a function for the `IN_WIDTH`→(address, fraction) split.
- Sub-module `act_rr_arbiter`: combinational round-robin priority search over `req` given `ptr`; outputs `gnt_valid` and `gnt_idx`. The pointer register stays in the scheduler.

## Test plan
LUT model: `lut[i]=16*i` for i=0..7, `lut[i]=16*i-256` for i=8..15, `next__data` clamped at address 7 and wrapped 15→0.

- Single requester 0, input 0x25 -> `ack[0]` at cycle 4 with `res__data`=37 (interpolated: base 32, next 48, frac 5); 32 with the macro undefined, at cycle 3.
- Input 0x7A (clamped end) -> 112; input 0xF8 (wrap 15→0) -> -8; input 0x8F -> -113.
- All four `req` set from reset, inputs 0x10/0x20/0x30/0x40 -> acks in order 0,1,2,3 spaced 4 cycles apart with results 16/32/48/64.
- After requester 2 is served, `req`=4'b0101 -> requester 0 served before requester 2 (pointer at 3 wraps to 0).
- `rst` asserted during CALC -> next cycle all outputs 0, no `ack`; `req[1]` held -> served from a fresh IDLE with the correct result.
- Requester holds `req` through its `ack` cycle and drops it next cycle -> exactly one `ack`, no duplicate grant.

Source files
------------

// File: rtl/act_lut_sched_pkg.sv
// Shared types and helpers for the activation LUT scheduler.
// Optional interpolation is enabled with ACT_LUT_SCHED_INTERP_EN.
package act_lut_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } sched_state_e;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_IN_WIDTH   = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] frac;
    } in_split_t;

    // Upper bits select the LUT entry, the low fracWidth bits weight the step to the next one.
    function automatic in_split_t split_input(input logic [31:0] value,
                                              input int unsigned fracWidth);
        in_split_t s;
        s.addr = value >> fracWidth;
        s.frac = value & ((32'd1 << fracWidth) - 32'd1);
        return s;
    endfunction

endpackage

// File: rtl/act_rr_arbiter.sv
// Combinational round-robin search: first set request at or after ptr, modulo N_REQ.
// Part of the act_lut_scheduler slice (ACT_LUT_SCHED_INTERP_EN has no effect here).
module act_rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     gnt_valid,
    output logic [$clog2(N_REQ)-1:0] gnt_idx
);

    // Walk candidates from farthest to nearest so the nearest set bit wins.
    always_comb begin
        int cand;
        cand      = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = $clog2(N_REQ)'(cand);
            end
        end
    end

endmodule

// File: rtl/act_lut_scheduler.sv
// Shares one combinational activation LUT among N_REQ requesters, round-robin.
// Define ACT_LUT_SCHED_INTERP_EN to interpolate between adjacent LUT entries.
module act_lut_scheduler
    import act_lut_sched_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_WIDTH = IN_WIDTH - ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*IN_WIDTH-1:0]     req__data,
    output logic [N_REQ-1:0]              ack,
    output logic signed [DATA_WIDTH-1:0]  res__data,
    output logic                          res__valid,
    output logic [$clog2(N_REQ)-1:0]      res__id,
    output logic                          busy,
    output logic [ADDR_WIDTH-1:0]         address,
    input  logic signed [DATA_WIDTH-1:0]  base,
    input  logic signed [DATA_WIDTH-1:0]  next__data
);

    localparam int IDX_W = $clog2(N_REQ);

    sched_state_e                 state_q, state_d;
    logic [IDX_W-1:0]             ptr_q, ptr_d;
    logic [IDX_W-1:0]             gnt_q, gnt_d;
    logic [IN_WIDTH-1:0]          in_q, in_d;
    logic signed [DATA_WIDTH-1:0] res_q, res_d;
    logic [N_REQ-1:0]             ack_q, ack_d;
    logic                         valid_q, valid_d;
    logic [IDX_W-1:0]             id_q, id_d;
    logic                         busy_q, busy_d;

    logic                         gntValid;
    logic [IDX_W-1:0]             gntIdx;
    in_split_t                    inSplit;

    act_rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arbiter (
        .req      (req),
        .ptr      (ptr_q),
        .gnt_valid(gntValid),
        .gnt_idx  (gntIdx)
    );

    assign inSplit = split_input(32'(in_q), FRAC_WIDTH);
    assign address = ADDR_WIDTH'(inSplit.addr);

`ifdef ACT_LUT_SCHED_INTERP_EN
    localparam int PW = DATA_WIDTH + FRAC_WIDTH + 2;

    logic signed [DATA_WIDTH-1:0] b_q, b_d;
    logic signed [DATA_WIDTH-1:0] n_q, n_d;
    logic [FRAC_WIDTH-1:0]        f_q, f_d;
    logic signed [DATA_WIDTH:0]   diff;
    logic signed [PW-1:0]         prod;
    logic signed [DATA_WIDTH:0]   shifted;
    logic signed [DATA_WIDTH-1:0] resCalc;

    // Floor-shifted weighted step stays within [b_q, n_q], so the final truncation is lossless.
    assign diff    = {n_q[DATA_WIDTH-1], n_q} - {b_q[DATA_WIDTH-1], b_q};
    assign prod    = $signed({{(PW-DATA_WIDTH-1){diff[DATA_WIDTH]}}, diff})
                   * $signed({{(PW-FRAC_WIDTH){1'b0}}, f_q});
    assign shifted = (DATA_WIDTH+1)'(prod >>> FRAC_WIDTH);
    assign resCalc = DATA_WIDTH'(shifted + $signed({b_q[DATA_WIDTH-1], b_q}));

    always_comb begin
        b_d = b_q;
        n_d = n_q;
        f_d = f_q;
        if (state_q == ADDR) begin
            b_d = base;
            n_d = next__data;
            f_d = FRAC_WIDTH'(inSplit.frac);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_q <= '0;
            n_q <= '0;
            f_q <= '0;
        end else begin
            b_q <= b_d;
            n_q <= n_d;
            f_q <= f_d;
        end
    end
`else
    logic unusedFrac;
    logic unusedNext;

    assign unusedFrac = ^inSplit.frac;
    assign unusedNext = ^next__data;
`endif

    // Next-state logic; completion outputs are registered so they appear exactly in DONE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        in_d    = in_q;
        res_d   = res_q;
        ack_d   = '0;
        valid_d = 1'b0;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (gntValid) begin
                    gnt_d   = gntIdx;
                    in_d    = req__data[gntIdx*IN_WIDTH +: IN_WIDTH];
                    state_d = ADDR;
                end
            end
            ADDR: begin
`ifdef ACT_LUT_SCHED_INTERP_EN
                state_d = CALC;
`else
                res_d        = base;
                ack_d[gnt_q] = 1'b1;
                valid_d      = 1'b1;
                id_d         = gnt_q;
                state_d      = DONE;
`endif
            end
`ifdef ACT_LUT_SCHED_INTERP_EN
            CALC: begin
                res_d        = resCalc;
                ack_d[gnt_q] = 1'b1;
                valid_d      = 1'b1;
                id_d         = gnt_q;
                state_d      = DONE;
            end
`endif
            DONE: begin
                ptr_d   = (int'(gnt_q) == N_REQ - 1) ? '0 : gnt_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            in_q    <= '0;
            res_q   <= '0;
            ack_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            in_q    <= in_d;
            res_q   <= res_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
        end
    end

    assign ack        = ack_q;
    assign res__data  = res_q;
    assign res__valid = valid_q;
    assign res__id    = id_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_act_lut_scheduler.sv
// Directed bench for act_lut_scheduler; expectations follow ACT_LUT_SCHED_INTERP_EN.
`timescale 1ns/1ps
module tb_act_lut_scheduler;

    localparam int N_REQ      = 4;
    localparam int IN_WIDTH   = 8;
    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 8;
`ifdef ACT_LUT_SCHED_INTERP_EN
    localparam bit INTERP    = 1'b1;
    localparam int ACK_EDGES = 3;
    localparam int SPACING   = 4;
`else
    localparam bit INTERP    = 1'b0;
    localparam int ACK_EDGES = 2;
    localparam int SPACING   = 3;
`endif

    typedef struct {
        logic [7:0] inData;
        int         expAddr;
        int         expInterp;
        int         expBase;
    } vec_t;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic [N_REQ-1:0]             req = '0;
    logic [N_REQ*IN_WIDTH-1:0]    reqData = '0;
    logic [N_REQ-1:0]             ack;
    logic signed [DATA_WIDTH-1:0] resData;
    logic                         resValid;
    logic [1:0]                   resId;
    logic                         busy;
    logic [ADDR_WIDTH-1:0]        address;
    logic signed [DATA_WIDTH-1:0] base;
    logic signed [DATA_WIDTH-1:0] nextData;

    int   assertCount = 0;
    int   failCount   = 0;
    vec_t vecs[8];

    act_lut_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req__data (reqData),
        .ack       (ack),
        .res__data (resData),
        .res__valid(resValid),
        .res__id   (resId),
        .busy      (busy),
        .address   (address),
        .base      (base),
        .next__data(nextData)
    );

    always #5 clk = ~clk;

    // LUT model: positive ramp in the lower half, negative in the upper, clamped at 7, wrapping 15 to 0.
    function automatic logic signed [7:0] lutVal(input int i);
        return (i < 8) ? 8'(16 * i) : 8'(16 * i - 256);
    endfunction

    always_comb begin
        base     = lutVal(int'(address));
        nextData = (address == 4'd7) ? lutVal(7) : lutVal((int'(address) + 1) % 16);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [7:0] data);
        reqData[idx*IN_WIDTH +: IN_WIDTH] = data;
        req[idx] = 1'b1;
    endtask

    task automatic waitAck(output int edges);
        bit seen;
        seen  = 1'b0;
        edges = 0;
        while (!seen && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (ack != '0) seen = 1'b1;
        end
        if (!seen) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL ack_timeout: got no ack, expected ack within 20 cycles");
        end
    endtask

    task automatic doReset();
        rst     = 1'b1;
        req     = '0;
        reqData = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int edges;
        int who;
        int extraAcks;

        vecs[0] = '{8'h25,  2,   37,   32};
        vecs[1] = '{8'h7A,  7,  112,  112};
        vecs[2] = '{8'hF8, 15,   -8,  -16};
        vecs[3] = '{8'h8F,  8, -113, -128};
        vecs[4] = '{8'h00,  0,    0,    0};
        vecs[5] = '{8'h3F,  3,   63,   48};
        vecs[6] = '{8'hC4, 12,  -60,  -64};
        vecs[7] = '{8'h6C,  6,  108,   96};

        $display("[TB] starting, interpolation=%0d", INTERP);
        doReset();
        checkOutput("reset_ack", int'(ack), 0);
        checkOutput("reset_valid", int'(resValid), 0);
        checkOutput("reset_data", int'(resData), 0);
        checkOutput("reset_id", int'(resId), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_address", int'(address), 0);

        // Single-requester vectors, rotating through requesters.
        for (int v = 0; v < 8; v++) begin
            who = v % N_REQ;
            applyStimulus(who, vecs[v].inData);
            @(posedge clk);
            #1;
            checkOutput("busy_after_grant", int'(busy), 1);
            checkOutput("address", int'(address), vecs[v].expAddr);
            waitAck(edges);
            checkOutput("latency", edges + 1, ACK_EDGES);
            checkOutput("ack_onehot", int'(ack), 1 << who);
            checkOutput("res_valid", int'(resValid), 1);
            checkOutput("res_id", int'(resId), who);
            checkOutput("res_data", int'(resData), INTERP ? vecs[v].expInterp : vecs[v].expBase);
            req[who] = 1'b0;
            @(posedge clk);
            #1;
            checkOutput("ack_clear", int'(ack), 0);
            checkOutput("valid_clear", int'(resValid), 0);
            checkOutput("busy_idle", int'(busy), 0);
        end

        // All four requesters from reset: served in order, evenly spaced.
        doReset();
        reqData = {8'h40, 8'h30, 8'h20, 8'h10};
        req     = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            waitAck(edges);
            checkOutput("rr_spacing", edges, (k == 0) ? ACK_EDGES : SPACING);
            checkOutput("rr_ack", int'(ack), 1 << k);
            checkOutput("rr_id", int'(resId), k);
            checkOutput("rr_data", int'(resData), 16 * (k + 1));
            req[k] = 1'b0;
        end
        @(posedge clk);
        #1;

        // Pointer wrap: after requester 2, requester 0 precedes requester 2.
        applyStimulus(2, 8'h20);
        waitAck(edges);
        checkOutput("wrap_first_id", int'(resId), 2);
        req[2] = 1'b0;
        @(posedge clk);
        #1;
        reqData[0*IN_WIDTH +: IN_WIDTH] = 8'h30;
        reqData[2*IN_WIDTH +: IN_WIDTH] = 8'h50;
        req = 4'b0101;
        waitAck(edges);
        checkOutput("wrap_id_0", int'(resId), 0);
        checkOutput("wrap_data_0", int'(resData), 48);
        req[0] = 1'b0;
        waitAck(edges);
        checkOutput("wrap_id_2", int'(resId), 2);
        checkOutput("wrap_data_2", int'(resData), 80);
        req[2] = 1'b0;
        @(posedge clk);
        #1;

        // Reset while the result is being formed drops the request silently.
        applyStimulus(1, 8'h25);
        repeat (ACK_EDGES - 1) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_ack", int'(ack), 0);
        checkOutput("midrst_valid", int'(resValid), 0);
        checkOutput("midrst_data", int'(resData), 0);
        checkOutput("midrst_id", int'(resId), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_address", int'(address), 0);
        rst = 1'b0;
        waitAck(edges);
        checkOutput("midrst_latency", edges, ACK_EDGES);
        checkOutput("midrst_reserve_id", int'(resId), 1);
        checkOutput("midrst_reserve_data", int'(resData), INTERP ? 37 : 32);
        req[1] = 1'b0;
        @(posedge clk);
        #1;

        // Request held through the ack cycle must not be granted twice.
        applyStimulus(3, 8'h7A);
        waitAck(edges);
        checkOutput("hold_id", int'(resId), 3);
        checkOutput("hold_data", int'(resData), 112);
        @(posedge clk);
        #1;
        checkOutput("hold_ack_gone", int'(ack), 0);
        checkOutput("hold_not_regranted", int'(busy), 0);
        req[3] = 1'b0;
        extraAcks = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ack != '0) extraAcks++;
        end
        checkOutput("no_duplicate_ack", extraAcks, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
